// File: rtl/matmul_pkg.sv
// Shared types and sizing helpers for the matrix operand sequencer.
package matmul_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RUN     = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } state_t;

   localparam int DEFAULT_MAT_DIM = 3;

   // Row-major index width for an n x n matrix; never narrower than one bit.
   function automatic int idx_width(input int n);
      return (n * n > 1) ? $clog2(n * n) : 1;
   endfunction

endpackage

// File: rtl/matrix_operand_sequencer_if.sv
// Host and data-path signal bundle for matrix_operand_sequencer.
interface matrix_operand_sequencer_if
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAT_DIM    = DEFAULT_MAT_DIM
);
   localparam int IDX_W = idx_width(MAT_DIM);

   logic                  wr_en;
   logic                  wr_sel;
   logic [IDX_W-1:0]      wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  start;
   logic                  busy;
   logic                  done;
   logic [IDX_W-1:0]      rd_addr;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  rd_invalid;
   logic                  ovf_any;
   logic [DATA_WIDTH-1:0] dp_inData_A;
   logic [DATA_WIDTH-1:0] dp_inData_B;
   logic                  dp_en_Mux;
   logic                  dp_en_PPReg;
   logic                  dp_en_FDReg;
   logic [DATA_WIDTH-1:0] dp_outData;
   logic                  dp_resultIsInvalid;

   modport slave (
      input  wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
             dp_outData, dp_resultIsInvalid,
      output busy, done, rd_data, rd_invalid, ovf_any,
             dp_inData_A, dp_inData_B, dp_en_Mux, dp_en_PPReg, dp_en_FDReg
   );

   modport master (
      output wr_en, wr_sel, wr_addr, wr_data, start, rd_addr,
             dp_outData, dp_resultIsInvalid,
      input  busy, done, rd_data, rd_invalid, ovf_any,
             dp_inData_A, dp_inData_B, dp_en_Mux, dp_en_PPReg, dp_en_FDReg
   );

endinterface

// File: rtl/matrix_regfile.sv
// N x N element store: synchronous write, combinational read, async clear.
module matrix_regfile
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAT_DIM    = DEFAULT_MAT_DIM
)(
   input  logic                               clk,
   input  logic                               reset_n,
   input  logic                               wr_en,
   input  logic [idx_width(MAT_DIM)-1:0]      wr_addr,
   input  logic [DATA_WIDTH-1:0]              wr_data,
   input  logic [idx_width(MAT_DIM)-1:0]      rd_addr,
   output logic [DATA_WIDTH-1:0]              rd_data
);
   localparam int IDX_W = idx_width(MAT_DIM);
   // Sized to the full address space so no address can index out of range.
   localparam int DEPTH = 2 ** IDX_W;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int n = 0; n < DEPTH; n++) mem[n] <= '0;
      end else if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/matrix_operand_sequencer.sv
// Sequences A/B operand pairs into the MAC data path and captures C results.
// Optional OPSEQ_OVF_SATURATE_EN: overflowed results are stored as all-ones.
//
// state   | meaning
// IDLE    | accepts operand writes and start
// RUN     | one A[i][k]*B[k][j] term per cycle, k = 0..N-1
// CAPTURE | stores dp result and invalid flag into C[i][j]
// DONE    | one-cycle completion pulse
module matrix_operand_sequencer
   import matmul_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int MAT_DIM    = DEFAULT_MAT_DIM
)(
   input logic                      clk,
   input logic                      reset_n,
   matrix_operand_sequencer_if.slave bus
);
   localparam int               IDX_W = idx_width(MAT_DIM);
   localparam int               DEPTH = 2 ** IDX_W;
   localparam logic [IDX_W-1:0] LAST  = IDX_W'(MAT_DIM - 1);
   localparam logic [IDX_W-1:0] DIM   = IDX_W'(MAT_DIM);
   localparam logic [IDX_W-1:0] ONE   = IDX_W'(1);

   state_t                state;
   state_t                state_next;
   logic [IDX_W-1:0]      i;
   logic [IDX_W-1:0]      j;
   logic [IDX_W-1:0]      k;
   logic                  ovf_q;
   logic [IDX_W-1:0]      addr_a;
   logic [IDX_W-1:0]      addr_b;
   logic [IDX_W-1:0]      addr_c;
   logic [DATA_WIDTH-1:0] a_val;
   logic [DATA_WIDTH-1:0] b_val;
   logic [DATA_WIDTH-1:0] c_rd;
   logic [DATA_WIDTH-1:0] c_wdata;
   logic                  a_we;
   logic                  b_we;
   logic                  c_we;
   logic [DEPTH-1:0]      c_flag;

   assign addr_a = i * DIM + k;
   assign addr_b = k * DIM + j;
   assign addr_c = i * DIM + j;

   assign a_we = bus.wr_en && (state == IDLE) && !bus.wr_sel;
   assign b_we = bus.wr_en && (state == IDLE) &&  bus.wr_sel;
   assign c_we = (state == CAPTURE);

`ifdef OPSEQ_OVF_SATURATE_EN
   assign c_wdata = bus.dp_resultIsInvalid ? {DATA_WIDTH{1'b1}} : bus.dp_outData;
`else
   assign c_wdata = bus.dp_outData;
`endif

   matrix_regfile #(.DATA_WIDTH(DATA_WIDTH), .MAT_DIM(MAT_DIM)) u_mat_a (
      .clk(clk), .reset_n(reset_n), .wr_en(a_we), .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data), .rd_addr(addr_a), .rd_data(a_val)
   );

   matrix_regfile #(.DATA_WIDTH(DATA_WIDTH), .MAT_DIM(MAT_DIM)) u_mat_b (
      .clk(clk), .reset_n(reset_n), .wr_en(b_we), .wr_addr(bus.wr_addr),
      .wr_data(bus.wr_data), .rd_addr(addr_b), .rd_data(b_val)
   );

   matrix_regfile #(.DATA_WIDTH(DATA_WIDTH), .MAT_DIM(MAT_DIM)) u_mat_c (
      .clk(clk), .reset_n(reset_n), .wr_en(c_we), .wr_addr(addr_c),
      .wr_data(c_wdata), .rd_addr(bus.rd_addr), .rd_data(c_rd)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = RUN;
         RUN:     if (k == LAST) state_next = CAPTURE;
         CAPTURE: state_next = (i == LAST && j == LAST) ? DONE : RUN;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         i     <= '0;
         j     <= '0;
         k     <= '0;
         ovf_q <= 1'b0;
      end else begin
         case (state)
            IDLE: if (bus.start) begin
               i     <= '0;
               j     <= '0;
               k     <= '0;
               ovf_q <= 1'b0;
            end
            RUN: if (k != LAST) k <= k + ONE;
            CAPTURE: begin
               k     <= '0;
               ovf_q <= ovf_q | bus.dp_resultIsInvalid;
               if (j == LAST) begin
                  j <= '0;
                  i <= i + ONE;
               end else begin
                  j <= j + ONE;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)  c_flag         <= '0;
      else if (c_we) c_flag[addr_c] <= bus.dp_resultIsInvalid;
   end

   always_comb begin
      bus.dp_inData_A = '0;
      bus.dp_inData_B = '0;
      bus.dp_en_Mux   = 1'b0;
      bus.dp_en_PPReg = 1'b0;
      bus.dp_en_FDReg = 1'b0;
      if (state == RUN) begin
         bus.dp_inData_A = a_val;
         bus.dp_inData_B = b_val;
         // k == 0 starts a fresh accumulation instead of adding to the old sum.
         bus.dp_en_Mux   = (k != '0);
         bus.dp_en_PPReg = 1'b1;
         bus.dp_en_FDReg = (k == LAST);
      end
   end

   assign bus.busy       = (state == RUN) || (state == CAPTURE);
   assign bus.done       = (state == DONE);
   assign bus.ovf_any    = ovf_q;
   assign bus.rd_data    = c_rd;
   assign bus.rd_invalid = c_flag[bus.rd_addr];

endmodule

// File: tb/tb_matrix_operand_sequencer.sv
// Self-checking bench: behavioural MAC data path plus a matrix-product reference.
module tb_matrix_operand_sequencer;
   localparam int N  = 3;
   localparam int W  = 8;
   localparam int NN = N * N;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   matrix_operand_sequencer_if #(.DATA_WIDTH(W), .MAT_DIM(N)) bus ();
   matrix_operand_sequencer #(.DATA_WIDTH(W), .MAT_DIM(N)) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   int checks = 0;
   int failures = 0;
   int ma [NN];
   int mb [NN];

   // Data path: accumulate on PPReg, restart on !Mux, final register on FDReg.
   int            acc;
   logic [W-1:0]  fd;
   logic          fd_inv;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         acc    <= 0;
         fd     <= '0;
         fd_inv <= 1'b0;
      end else if (bus.dp_en_PPReg) begin
         acc <= (bus.dp_en_Mux ? acc : 0) + int'(bus.dp_inData_A) * int'(bus.dp_inData_B);
         if (bus.dp_en_FDReg) begin
            fd     <= W'((bus.dp_en_Mux ? acc : 0) + int'(bus.dp_inData_A) * int'(bus.dp_inData_B));
            fd_inv <= ((bus.dp_en_Mux ? acc : 0) + int'(bus.dp_inData_A) * int'(bus.dp_inData_B)) > 255;
         end
      end
   end
   assign bus.dp_outData         = fd;
   assign bus.dp_resultIsInvalid = fd_inv;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ref_sum(input int r, input int c);
      int s = 0;
      for (int t = 0; t < N; t++) s += ma[r*N + t] * mb[t*N + c];
      return s;
   endfunction

   task automatic wr(input bit sel, input int addr, input int data);
      bus.wr_en   = 1'b1;
      bus.wr_sel  = sel;
      bus.wr_addr = 4'(addr);
      bus.wr_data = 8'(data);
      @(negedge clk);
      bus.wr_en = 1'b0;
   endtask

   task automatic load_model();
      for (int a = 0; a < NN; a++) wr(1'b0, a, ma[a]);
      for (int a = 0; a < NN; a++) wr(1'b1, a, mb[a]);
   endtask

   task automatic check_c(input string tag);
      bit any = 0;
      for (int a = 0; a < NN; a++) begin
         int s;
         int ed;
         bit inv;
         bus.rd_addr = 4'(a);
         #1;
         s   = ref_sum(a / N, a % N);
         inv = (s > 255);
`ifdef OPSEQ_OVF_SATURATE_EN
         ed = inv ? 255 : (s % 256);
`else
         ed = s % 256;
`endif
         any |= inv;
         check($sformatf("%s_c%0d", tag, a), bus.rd_data, ed);
         check($sformatf("%s_inv%0d", tag, a), bus.rd_invalid, inv);
      end
      check({tag, "_ovf_any"}, bus.ovf_any, any);
      @(negedge clk);
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_busy"}, bus.busy, 1'b0);
      check({tag, "_done"}, bus.done, 1'b0);
      check({tag, "_ovf"}, bus.ovf_any, 1'b0);
      check({tag, "_dpA"}, bus.dp_inData_A, 8'h00);
      check({tag, "_dpB"}, bus.dp_inData_B, 8'h00);
      check({tag, "_strobes"}, {bus.dp_en_Mux, bus.dp_en_PPReg, bus.dp_en_FDReg}, 3'b000);
   endtask

   // Starts a run (start sampled at edge 0) and watches cycles 1..45.
   task automatic run(input string tag, input bit strobe_chk, input bit inject);
      int done_cyc = -1;
      int done_cnt = 0;
      int busy_bad = 0;
      logic [7:0] sa [5];
      logic [7:0] sb [5];
      logic [2:0] sst [5];
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      bus.wr_en = 1'b0;
      for (int c = 1; c <= 45; c++) begin
         if (bus.busy !== ((c <= N*N*(N+1)) ? 1'b1 : 1'b0)) busy_bad++;
         if (bus.done === 1'b1) begin
            done_cnt++;
            if (done_cyc < 0) done_cyc = c;
         end
         if (c <= 4) begin
            sa[c]  = bus.dp_inData_A;
            sb[c]  = bus.dp_inData_B;
            sst[c] = {bus.dp_en_Mux, bus.dp_en_PPReg, bus.dp_en_FDReg};
         end
         bus.wr_en = 1'b0;
         bus.start = 1'b0;
         if (inject && c == 5) begin
            bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'h55;
         end
         if (inject && (c == 10 || c == 37)) bus.start = 1'b1;
         @(negedge clk);
      end
      bus.wr_en = 1'b0;
      bus.start = 1'b0;
      check({tag, "_done_cycle"}, done_cyc, N*N*(N+1)+1);
      check({tag, "_done_count"}, done_cnt, 1);
      check({tag, "_busy_window"}, busy_bad, 0);
      if (strobe_chk) begin
         check({tag, "_k0_strobes"}, sst[1], 3'b010);
         check({tag, "_k1_strobes"}, sst[2], 3'b110);
         check({tag, "_k2_strobes"}, sst[3], 3'b111);
         check({tag, "_cap_strobes"}, sst[4], 3'b000);
         check({tag, "_pair0"}, {sa[1], sb[1]}, {8'(ma[0]), 8'(mb[0])});
         check({tag, "_pair1"}, {sa[2], sb[2]}, {8'(ma[1]), 8'(mb[3])});
         check({tag, "_pair2"}, {sa[3], sb[3]}, {8'(ma[2]), 8'(mb[6])});
         check({tag, "_cap_ops"}, {sa[4], sb[4]}, 16'h0000);
      end
   endtask

   initial begin
      bus.wr_en = 1'b0; bus.wr_sel = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
      bus.start = 1'b0; bus.rd_addr = '0;
      for (int a = 0; a < NN; a++) begin ma[a] = 0; mb[a] = 0; end
      repeat (3) @(negedge clk);
      #1;
      check_idle_outputs("reset");
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check_c("reset");

      // Identity times 1..9, with strobe and operand-pair monitoring.
      for (int a = 0; a < NN; a++) begin ma[a] = (a / N == a % N) ? 1 : 0; mb[a] = a + 1; end
      load_model();
      run("ident", 1'b1, 1'b0);
      check_c("ident");

      for (int a = 0; a < NN; a++) begin ma[a] = 2; mb[a] = 3; end
      load_model();
      run("uniform", 1'b0, 1'b0);
      check_c("uniform");

      for (int a = 0; a < NN; a++) begin ma[a] = 16; mb[a] = 16; end
      load_model();
      run("ovf", 1'b0, 1'b0);
      check_c("ovf");

      for (int r = 0; r < 3; r++) begin
         for (int a = 0; a < NN; a++) begin
            ma[a] = (r == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
            mb[a] = (r == 0) ? int'($urandom_range(0, 9)) : int'($urandom_range(0, 255));
         end
         load_model();
         run($sformatf("rand%0d", r), 1'b1, 1'b0);
         check_c($sformatf("rand%0d", r));
      end

      // Writes and start while busy must be ignored; model stays unchanged.
      for (int a = 0; a < NN; a++) begin ma[a] = int'($urandom_range(1, 9)); mb[a] = int'($urandom_range(1, 9)); end
      load_model();
      run("ignore", 1'b1, 1'b1);
      check_c("ignore");

      // Write in the same cycle as start: the run must see the new A[0].
      ma[0] = int'($urandom_range(10, 20));
      bus.wr_en = 1'b1; bus.wr_sel = 1'b0; bus.wr_addr = 4'd0; bus.wr_data = 8'(ma[0]);
      run("wr_start", 1'b1, 1'b0);
      check_c("wr_start");

      // Reset at cycle 15 of a run clears everything and suppresses done.
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (14) @(negedge clk);
      reset_n = 1'b0;
      #1;
      check_idle_outputs("midreset");
      for (int a = 0; a < NN; a++) begin ma[a] = 0; mb[a] = 0; end
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("midreset_no_done", bus.done, 1'b0);
      check_c("midreset");

      for (int a = 0; a < NN; a++) begin ma[a] = int'($urandom_range(0, 255)); mb[a] = int'($urandom_range(0, 255)); end
      load_model();
      run("post_reset", 1'b1, 1'b0);
      check_c("post_reset");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
